id_control_unit: RTL and testbench

Instruction-decode stage main control with ID/EX control pipeline register. Decodes the IF/ID instruction into datapath controls and the 3-bit ALUOp/6-bit function pair consumed by the EX-stage ALU control. It registers them into the ID/EX stage, detects load-use hazards against the instruction currently in EX, and inserts bubbles on stall or branch flush.

---
 rtl/id_control_unit_pkg.sv | 116 +++++++++++
 rtl/id_control_unit_if.sv | 48 ++++
 rtl/id_hazard_detect.sv | 31 +++
 rtl/id_control_unit.sv | 112 +++++++++++
 tb/tb_id_control_unit.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_control_unit_pkg.sv
// -----------------------------------------------------------------------------
// id_control_unit_pkg
// Shared decode definitions for the ID-stage main control:
//   - MIPS-32 opcode constants for the supported subset
//   - ALUOp encodings consumed by the EX-stage ALU control
//   - ctrl_t   : packed datapath control bundle
//   - idex_t   : full ID/EX pipeline register contents
//   - decode() : opcode -> {legal, rt_used, ctrl}
// -----------------------------------------------------------------------------
package id_control_unit_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    typedef enum logic [2:0] {
        ALUOP_AND   = 3'b000,
        ALUOP_OR    = 3'b001,
        ALUOP_ADD   = 3'b010,
        ALUOP_SUB   = 3'b011,
        ALUOP_RTYPE = 3'b100
    } aluop_e;

    typedef struct packed {
        logic   reg_dst;
        logic   alu_src;
        logic   mem_read;
        logic   mem_write;
        logic   mem_to_reg;
        logic   reg_write;
        logic   branch;
        aluop_e alu_op;
    } ctrl_t;

    // A bubble still carries ALUOp=ADD so the EX ALU sees a harmless op.
    localparam ctrl_t CTRL_BUBBLE = '{
        reg_dst: 1'b0, alu_src: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
        mem_to_reg: 1'b0, reg_write: 1'b0, branch: 1'b0, alu_op: ALUOP_ADD
    };

    typedef struct packed {
        logic        valid;
        ctrl_t       ctrl;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] imm;
    } idex_t;

    localparam idex_t IDEX_BUBBLE = '{
        valid: 1'b0, ctrl: CTRL_BUBBLE, funct: 6'd0,
        rs: 5'd0, rt: 5'd0, rd: 5'd0, imm: 32'd0
    };

    typedef struct packed {
        logic  legal;
        logic  rt_used;   // rt is a source operand (hazard relevant)
        ctrl_t ctrl;
    } dec_t;

    function automatic dec_t decode(input logic [5:0] op);
        dec_t d;
        d.legal   = 1'b1;
        d.rt_used = 1'b0;
        d.ctrl    = CTRL_BUBBLE;
        case (op)
            OP_RTYPE: begin
                d.ctrl.alu_op    = ALUOP_RTYPE;
                d.ctrl.reg_dst   = 1'b1;
                d.ctrl.reg_write = 1'b1;
                d.rt_used        = 1'b1;
            end
            OP_LW: begin
                d.ctrl.alu_op     = ALUOP_ADD;
                d.ctrl.alu_src    = 1'b1;
                d.ctrl.mem_read   = 1'b1;
                d.ctrl.mem_to_reg = 1'b1;
                d.ctrl.reg_write  = 1'b1;
            end
            OP_SW: begin
                d.ctrl.alu_op    = ALUOP_ADD;
                d.ctrl.alu_src   = 1'b1;
                d.ctrl.mem_write = 1'b1;
                d.rt_used        = 1'b1;
            end
            OP_BEQ: begin
                d.ctrl.alu_op = ALUOP_SUB;
                d.ctrl.branch = 1'b1;
                d.rt_used     = 1'b1;
            end
            OP_ADDI: begin
                d.ctrl.alu_op    = ALUOP_ADD;
                d.ctrl.alu_src   = 1'b1;
                d.ctrl.reg_write = 1'b1;
            end
            OP_ANDI: begin
                d.ctrl.alu_op    = ALUOP_AND;
                d.ctrl.alu_src   = 1'b1;
                d.ctrl.reg_write = 1'b1;
            end
            OP_ORI: begin
                d.ctrl.alu_op    = ALUOP_OR;
                d.ctrl.alu_src   = 1'b1;
                d.ctrl.reg_write = 1'b1;
            end
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/id_control_unit_if.sv
// -----------------------------------------------------------------------------
// id_control_unit_if
// Bundles the IF/ID inputs and ID/EX outputs of id_control_unit.
//   slave  : the control unit (consumes instruction, drives ID/EX controls)
//   master : the surrounding pipeline / testbench
// Signals: Instr__i, InstrValid__i, Flush__i -> unit;
//          Stall__o, IllegalOp__o, Valid__o, ALUOp__o, ALUFunction__o,
//          RegDst..Branch, Rs/Rt/Rd__o, Imm__o, StallCount__o, FlushCount__o <- unit
// -----------------------------------------------------------------------------
interface id_control_unit_if;
    logic [31:0] Instr__i;
    logic        InstrValid__i;
    logic        Flush__i;
    logic        Stall__o;
    logic        IllegalOp__o;
    logic        Valid__o;
    logic [2:0]  ALUOp__o;
    logic [5:0]  ALUFunction__o;
    logic        RegDst__o;
    logic        ALUSrc__o;
    logic        MemRead__o;
    logic        MemWrite__o;
    logic        MemToReg__o;
    logic        RegWrite__o;
    logic        Branch__o;
    logic [4:0]  Rs__o;
    logic [4:0]  Rt__o;
    logic [4:0]  Rd__o;
    logic [31:0] Imm__o;
    logic [15:0] StallCount__o;
    logic [15:0] FlushCount__o;

    modport slave (
        input  Instr__i, InstrValid__i, Flush__i,
        output Stall__o, IllegalOp__o, Valid__o, ALUOp__o, ALUFunction__o,
               RegDst__o, ALUSrc__o, MemRead__o, MemWrite__o, MemToReg__o,
               RegWrite__o, Branch__o, Rs__o, Rt__o, Rd__o, Imm__o,
               StallCount__o, FlushCount__o
    );

    modport master (
        output Instr__i, InstrValid__i, Flush__i,
        input  Stall__o, IllegalOp__o, Valid__o, ALUOp__o, ALUFunction__o,
               RegDst__o, ALUSrc__o, MemRead__o, MemWrite__o, MemToReg__o,
               RegWrite__o, Branch__o, Rs__o, Rt__o, Rd__o, Imm__o,
               StallCount__o, FlushCount__o
    );
endinterface

// File: rtl/id_hazard_detect.sv
// -----------------------------------------------------------------------------
// id_hazard_detect
// Combinational load-use hazard check between the instruction in ID and a
// load sitting in ID/EX.
// Ports:
//   InstrValid_i, Flush_i : ID slot qualifiers (a flushed slot never stalls)
//   IdRs_i, IdRt_i        : ID-stage source specifiers
//   RtUsed_i              : ID instruction reads rt as a source
//   ExValid_i, ExMemRead_i, ExRt_i : ID/EX register state
//   Stall_o               : freeze PC and IF/ID, bubble ID/EX
// -----------------------------------------------------------------------------
module id_hazard_detect (
    input  logic       InstrValid_i,
    input  logic       Flush_i,
    input  logic [4:0] IdRs_i,
    input  logic [4:0] IdRt_i,
    input  logic       RtUsed_i,
    input  logic       ExValid_i,
    input  logic       ExMemRead_i,
    input  logic [4:0] ExRt_i,
    output logic       Stall_o
);
    logic rs_hit;
    logic rt_hit;

    assign rs_hit  = (ExRt_i == IdRs_i);
    assign rt_hit  = RtUsed_i & (ExRt_i == IdRt_i);
    // $0 is hardwired, so a load targeting it never produces a dependency.
    assign Stall_o = InstrValid_i & ~Flush_i & ExValid_i & ExMemRead_i &
                     (ExRt_i != 5'd0) & (rs_hit | rt_hit);
endmodule

// File: rtl/id_control_unit.sv
// -----------------------------------------------------------------------------
// id_control_unit
// ID-stage main control: decodes the IF/ID instruction, registers controls and
// operand fields into ID/EX, detects load-use hazards and inserts bubbles on
// stall, flush, invalid or illegal instructions.
// Ports:
//   Clock__i : clock, rising edge
//   Reset__i : asynchronous active-high reset (all outputs -> bubble)
//   bus      : id_control_unit_if.slave (instruction in, ID/EX controls out)
// Optional feature: `define ID_CTRL_PERF_EN adds 16-bit saturating stall/flush
// counters; otherwise StallCount__o/FlushCount__o are tied to 0.
// -----------------------------------------------------------------------------
module id_control_unit
    import id_control_unit_pkg::*;
(
    input  logic             Clock__i,
    input  logic             Reset__i,
    id_control_unit_if.slave bus
);
    dec_t  dec;
    idex_t idex_d, idex_q;
    logic  ill_d, ill_q;
    logic  stall;

    assign dec = decode(bus.Instr__i[31:26]);

    id_hazard_detect u_hazard (
        .InstrValid_i (bus.InstrValid__i),
        .Flush_i      (bus.Flush__i),
        .IdRs_i       (bus.Instr__i[25:21]),
        .IdRt_i       (bus.Instr__i[20:16]),
        .RtUsed_i     (dec.rt_used),
        .ExValid_i    (idex_q.valid),
        .ExMemRead_i  (idex_q.ctrl.mem_read),
        .ExRt_i       (idex_q.rt),
        .Stall_o      (stall)
    );

    always_comb begin
        idex_d = IDEX_BUBBLE;
        if (!bus.Flush__i && !stall && bus.InstrValid__i && dec.legal) begin
            idex_d.valid = 1'b1;
            idex_d.ctrl  = dec.ctrl;
            idex_d.funct = bus.Instr__i[5:0];
            idex_d.rs    = bus.Instr__i[25:21];
            idex_d.rt    = bus.Instr__i[20:16];
            idex_d.rd    = bus.Instr__i[15:11];
            idex_d.imm   = {{16{bus.Instr__i[15]}}, bus.Instr__i[15:0]};
        end
    end

    assign ill_d = bus.InstrValid__i & ~bus.Flush__i & ~dec.legal;

    always_ff @(posedge Clock__i or posedge Reset__i) begin
        if (Reset__i) begin
            idex_q <= IDEX_BUBBLE;
            ill_q  <= 1'b0;
        end else begin
            idex_q <= idex_d;
            ill_q  <= ill_d;
        end
    end

    assign bus.Stall__o       = stall;
    assign bus.IllegalOp__o   = ill_q;
    assign bus.Valid__o       = idex_q.valid;
    assign bus.ALUOp__o       = idex_q.ctrl.alu_op;
    assign bus.ALUFunction__o = idex_q.funct;
    assign bus.RegDst__o      = idex_q.ctrl.reg_dst;
    assign bus.ALUSrc__o      = idex_q.ctrl.alu_src;
    assign bus.MemRead__o     = idex_q.ctrl.mem_read;
    assign bus.MemWrite__o    = idex_q.ctrl.mem_write;
    assign bus.MemToReg__o    = idex_q.ctrl.mem_to_reg;
    assign bus.RegWrite__o    = idex_q.ctrl.reg_write;
    assign bus.Branch__o      = idex_q.ctrl.branch;
    assign bus.Rs__o          = idex_q.rs;
    assign bus.Rt__o          = idex_q.rt;
    assign bus.Rd__o          = idex_q.rd;
    assign bus.Imm__o         = idex_q.imm;

`ifdef ID_CTRL_PERF_EN
    logic [15:0] stall_cnt_d, stall_cnt_q;
    logic [15:0] flush_cnt_d, flush_cnt_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;
        // Only flushes that kill a real instruction are counted.
        if (bus.Flush__i && bus.InstrValid__i && flush_cnt_q != 16'hFFFF)
            flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge Clock__i or posedge Reset__i) begin
        if (Reset__i) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.StallCount__o = stall_cnt_q;
    assign bus.FlushCount__o = flush_cnt_q;
`else
    assign bus.StallCount__o = 16'd0;
    assign bus.FlushCount__o = 16'd0;
`endif

endmodule

// File: tb/tb_id_control_unit.sv
// -----------------------------------------------------------------------------
// tb_id_control_unit
// Self-checking bench for id_control_unit with a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_id_control_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_control_unit_if bus ();

    id_control_unit dut (
        .Clock__i (clk),
        .Reset__i (rst),
        .bus      (bus)
    );

    int vectors = 0;
    int errors  = 0;

    // Reference model of the ID/EX contents.
    // ctl bit order: {RegDst, ALUSrc, MemRead, MemWrite, MemToReg, RegWrite, Branch}
    bit        m_valid;
    bit [2:0]  m_aluop;
    bit [5:0]  m_func;
    bit [6:0]  m_ctl;
    bit [4:0]  m_rs, m_rt, m_rd;
    bit [31:0] m_imm;
    bit        m_ill;
    int        m_sc, m_fc;

    logic        got_stall, exp_stall;
    logic [96:0] got_out, exp_out;

    function automatic bit [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
        bit [31:0] w;
        w = {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn[5:0]};
        return w;
    endfunction

    function automatic bit [31:0] itype(input int op, input int rs, input int rt, input int imm);
        bit [31:0] w;
        w = {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
        return w;
    endfunction

    // Opcode table from the instruction-set description.
    function automatic void ref_decode(input bit [5:0] op, output bit ok,
                                       output bit [6:0] ctl, output bit [2:0] aop);
        ok = 1'b1;
        case (op)
            6'h00: begin ctl = 7'b1000010; aop = 3'd4; end
            6'h23: begin ctl = 7'b0110110; aop = 3'd2; end
            6'h2B: begin ctl = 7'b0101000; aop = 3'd2; end
            6'h04: begin ctl = 7'b0000001; aop = 3'd3; end
            6'h08: begin ctl = 7'b0100010; aop = 3'd2; end
            6'h0C: begin ctl = 7'b0100010; aop = 3'd0; end
            6'h0D: begin ctl = 7'b0100010; aop = 3'd1; end
            default: begin ok = 1'b0; ctl = 7'd0; aop = 3'd2; end
        endcase
    endfunction

    function automatic void model_bubble();
        m_valid = 0; m_aluop = 3'd2; m_func = 0; m_ctl = 0;
        m_rs = 0; m_rt = 0; m_rd = 0; m_imm = 0;
    endfunction

    function automatic void model_reset();
        model_bubble();
        m_ill = 0; m_sc = 0; m_fc = 0;
    endfunction

    function automatic bit ref_stall(input bit [31:0] ins, input bit v, input bit f);
        bit reads_rt;
        reads_rt = (ins[31:26] == 6'h00) || (ins[31:26] == 6'h2B) || (ins[31:26] == 6'h04);
        return v && !f && m_valid && m_ctl[4] && (m_rt != 0) &&
               ((m_rt == ins[25:21]) || (reads_rt && m_rt == ins[20:16]));
    endfunction

    function automatic void ref_update(input bit [31:0] ins, input bit v, input bit f, input bit st);
        bit ok; bit [6:0] ctl; bit [2:0] aop;
        ref_decode(ins[31:26], ok, ctl, aop);
        m_ill = v && !f && !ok;
`ifdef ID_CTRL_PERF_EN
        if (st && m_sc < 65535) m_sc++;
        if (f && v && m_fc < 65535) m_fc++;
`endif
        if (f || st || !v || !ok) model_bubble();
        else begin
            m_valid = 1; m_aluop = aop; m_ctl = ctl; m_func = ins[5:0];
            m_rs = ins[25:21]; m_rt = ins[20:16]; m_rd = ins[15:11];
            m_imm = {{16{ins[15]}}, ins[15:0]};
        end
    endfunction

    function automatic logic [96:0] model_vec();
        return {m_valid, m_aluop, m_func, m_ctl, m_rs, m_rt, m_rd, m_imm,
                m_ill, m_sc[15:0], m_fc[15:0]};
    endfunction

    function automatic logic [96:0] dut_vec();
        return {bus.Valid__o, bus.ALUOp__o, bus.ALUFunction__o,
                bus.RegDst__o, bus.ALUSrc__o, bus.MemRead__o, bus.MemWrite__o,
                bus.MemToReg__o, bus.RegWrite__o, bus.Branch__o,
                bus.Rs__o, bus.Rt__o, bus.Rd__o, bus.Imm__o,
                bus.IllegalOp__o, bus.StallCount__o, bus.FlushCount__o};
    endfunction

    // Called at posedge+1: apply inputs, sample Stall mid-cycle, clock, sample outputs.
    task automatic drive(input bit [31:0] ins, input bit v, input bit f);
        bus.Instr__i = ins; bus.InstrValid__i = v; bus.Flush__i = f;
        #2;
        got_stall = bus.Stall__o;
        exp_stall = ref_stall(ins, v, f);
        @(posedge clk);
        ref_update(ins, v, f, exp_stall);
        #1;
        got_out = dut_vec();
        exp_out = model_vec();
    endtask

    task automatic test_reset();
        bus.Instr__i = 0; bus.InstrValid__i = 0; bus.Flush__i = 0;
        model_reset();
        #12;
        vectors++;
        if (dut_vec() !== model_vec() || bus.Stall__o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got=%h stall=%b want=%h stall=0", dut_vec(), bus.Stall__o, model_vec());
        end
        rst = 0;
        drive(itype(6'h23, 9, 8, 0), 1, 0);              // lw $t0,0($t1)
        bus.Instr__i = rtype(8, 11, 10, 6'h20); bus.InstrValid__i = 1;
        #2;
        vectors++;
        if (bus.Stall__o !== 1'b1) begin
            errors++; $display("FAIL pre_reset_stall got=%b want=1", bus.Stall__o);
        end
        rst = 1;                                          // mid-cycle reset
        model_reset();
        #1;
        vectors++;
        if (dut_vec() !== model_vec() || bus.Stall__o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got=%h stall=%b want=%h stall=0", dut_vec(), bus.Stall__o, model_vec());
        end
        bus.InstrValid__i = 0;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_addi();
        drive(32'h21280005, 1, 0);
        vectors++;
        if (got_out !== exp_out || got_stall !== exp_stall) begin
            errors++; $display("FAIL addi_model got=%h want=%h", got_out, exp_out);
        end
        vectors++;
        if (bus.ALUOp__o !== 3'b010 || bus.ALUSrc__o !== 1'b1 || bus.RegWrite__o !== 1'b1 ||
            bus.Rt__o !== 5'd8 || bus.Imm__o !== 32'h5 || bus.Valid__o !== 1'b1) begin
            errors++;
            $display("FAIL addi_fields got aluop=%b src=%b rw=%b rt=%0d imm=%h v=%b want 010 1 1 8 00000005 1",
                     bus.ALUOp__o, bus.ALUSrc__o, bus.RegWrite__o, bus.Rt__o, bus.Imm__o, bus.Valid__o);
        end
        drive(itype(6'h0C, 9, 8, 16'h8001), 1, 0);       // andi, imm still sign-extended
        vectors++;
        if (got_out !== exp_out || bus.Imm__o !== 32'hFFFF8001) begin
            errors++; $display("FAIL andi_imm got=%h want=%h", got_out, exp_out);
        end
    endtask

    task automatic test_load_use();
        drive(itype(6'h23, 9, 8, 0), 1, 0);
        drive(rtype(8, 11, 10, 6'h20), 1, 0);
        vectors++;
        if (got_stall !== 1'b1 || exp_stall !== 1'b1 || bus.Valid__o !== 1'b0 || got_out !== exp_out) begin
            errors++; $display("FAIL load_use_stall got stall=%b v=%b out=%h want stall=1 v=0 out=%h",
                               got_stall, bus.Valid__o, got_out, exp_out);
        end
        drive(rtype(8, 11, 10, 6'h20), 1, 0);
        vectors++;
        if (got_stall !== 1'b0 || bus.ALUOp__o !== 3'b100 || bus.ALUFunction__o !== 6'b100000 ||
            bus.Valid__o !== 1'b1 || got_out !== exp_out) begin
            errors++; $display("FAIL load_use_issue got stall=%b aluop=%b fn=%b out=%h want 0 100 100000 %h",
                               got_stall, bus.ALUOp__o, bus.ALUFunction__o, got_out, exp_out);
        end
        drive(itype(6'h23, 9, 8, 0), 1, 0);              // lw then sw using rt
        drive(itype(6'h2B, 12, 8, 4), 1, 0);
        vectors++;
        if (got_stall !== 1'b1 || got_out !== exp_out) begin
            errors++; $display("FAIL sw_rt_hazard got stall=%b want 1", got_stall);
        end
        drive(itype(6'h23, 9, 8, 0), 1, 0);              // lw then addi: rt is a dest
        drive(itype(6'h08, 12, 8, 4), 1, 0);
        vectors++;
        if (got_stall !== 1'b0 || got_out !== exp_out) begin
            errors++; $display("FAIL addi_rt_nohazard got stall=%b want 0", got_stall);
        end
    endtask

    task automatic test_zero_reg();
        drive(itype(6'h23, 9, 0, 0), 1, 0);              // lw $0,0($t1)
        drive(rtype(0, 11, 10, 6'h20), 1, 0);            // add $t2,$0,$t3
        vectors++;
        if (got_stall !== 1'b0 || got_out !== exp_out) begin
            errors++; $display("FAIL zero_reg_rs got stall=%b want 0", got_stall);
        end
        drive(itype(6'h23, 9, 0, 0), 1, 0);
        drive(rtype(11, 0, 10, 6'h20), 1, 0);
        vectors++;
        if (got_stall !== 1'b0 || got_out !== exp_out) begin
            errors++; $display("FAIL zero_reg_rt got stall=%b want 0", got_stall);
        end
    endtask

    task automatic test_flush();
        int sc0, fc0;
        drive(itype(6'h23, 9, 8, 0), 1, 0);
        sc0 = bus.StallCount__o; fc0 = bus.FlushCount__o;
        drive(rtype(8, 11, 10, 6'h20), 1, 1);
        vectors++;
        if (got_stall !== 1'b0 || bus.Valid__o !== 1'b0 || got_out !== exp_out) begin
            errors++; $display("FAIL flush_hazard got stall=%b out=%h want stall=0 out=%h", got_stall, got_out, exp_out);
        end
`ifdef ID_CTRL_PERF_EN
        vectors++;
        if (int'(bus.FlushCount__o) !== fc0 + 1 || int'(bus.StallCount__o) !== sc0) begin
            errors++; $display("FAIL flush_counters got sc=%0d fc=%0d want sc=%0d fc=%0d",
                               bus.StallCount__o, bus.FlushCount__o, sc0, fc0 + 1);
        end
`else
        vectors++;
        if (bus.FlushCount__o !== 16'd0 || bus.StallCount__o !== 16'd0) begin
            errors++; $display("FAIL counters_off got sc=%0d fc=%0d want 0 0 (prev %0d %0d)",
                               bus.StallCount__o, bus.FlushCount__o, sc0, fc0);
        end
`endif
    endtask

    task automatic test_illegal();
        drive(32'hFC000000, 1, 0);
        vectors++;
        if (bus.IllegalOp__o !== 1'b1 || bus.Valid__o !== 1'b0 || got_out !== exp_out) begin
            errors++; $display("FAIL illegal_pulse got ill=%b v=%b want ill=1 v=0", bus.IllegalOp__o, bus.Valid__o);
        end
        drive(rtype(1, 2, 3, 6'h22), 1, 0);
        vectors++;
        if (bus.IllegalOp__o !== 1'b0 || got_out !== exp_out) begin
            errors++; $display("FAIL illegal_one_cycle got ill=%b want 0", bus.IllegalOp__o);
        end
        drive(32'hFC000000, 0, 0);
        vectors++;
        if (bus.IllegalOp__o !== 1'b0 || got_out !== exp_out) begin
            errors++; $display("FAIL illegal_invalid got ill=%b want 0", bus.IllegalOp__o);
        end
    endtask

    task automatic test_random();
        bit [5:0] ops [9] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h3F, 6'h02};
        for (int i = 0; i < 400; i++) begin
            bit [31:0] ins;
            bit v, f;
            ins = $urandom;
            ins[31:26] = ops[$urandom_range(0, 8)];
            ins[25:21] = 5'($urandom_range(0, 3));
            ins[20:16] = 5'($urandom_range(0, 3));
            v = ($urandom_range(0, 7) != 0);
            f = ($urandom_range(0, 7) == 0);
            drive(ins, v, f);
            vectors++;
            if (got_stall !== exp_stall || got_out !== exp_out) begin
                errors++;
                $display("FAIL random[%0d] ins=%h v=%b f=%b got stall=%b out=%h want stall=%b out=%h",
                         i, ins, v, f, got_stall, got_out, exp_stall, exp_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_use();
        test_zero_reg();
        test_flush();
        test_illegal();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
